pixel_stream_tx: RTL and testbench

PIXEL_STREAM_TX -- requirements
Module: pixel_stream_tx

---
 rtl/cnn_pkg.sv | 17 +
 rtl/pixel_stream_tx_if.sv | 30 +++
 rtl/pixel_stream_tx_skid_reg.sv | 62 ++++++
 rtl/pixel_stream_tx.sv | 130 +++++++++++++
 tb/tb_pixel_stream_tx.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cnn_pkg.sv
// Shared types and helpers for the pixel streaming blocks.
package cnn_pkg;

  // Frame transmitter states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FIN    = 2'd3
  } tx_state_t;

  // Width of a counter that must hold the values 0 .. n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pixel_stream_tx_if.sv
// Control, memory-read and pixel-output bundle of the frame transmitter.
// Signal directions are named from the transmitter's point of view.
interface pixel_stream_tx_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
);
  logic                  i_start;
  logic                  i_stall;
  logic                  o_mem_rd;
  logic [ADDR_WIDTH-1:0] o_mem_addr;
  logic [DATA_WIDTH-1:0] i_mem_data;
  logic [DATA_WIDTH-1:0] o_out;
  logic                  o_e;
  logic                  o_row_end;
  logic                  o_frame_end;
  logic                  o_busy;
  logic                  o_done;

  // Transmitter side.
  modport master (
    input  i_start, i_stall, i_mem_data,
    output o_mem_rd, o_mem_addr, o_out, o_e, o_row_end, o_frame_end, o_busy, o_done
  );

  // Controller / memory / downstream side.
  modport slave (
    output i_start, i_stall, i_mem_data,
    input  o_mem_rd, o_mem_addr, o_out, o_e, o_row_end, o_frame_end, o_busy, o_done
  );
endinterface

// File: rtl/pixel_stream_tx_skid_reg.sv
// Output register plus one-entry skid buffer. Returning memory data goes
// straight to the output register when it is free; if the output is held by
// a stall, the data parks in the skid entry and is presented next, so order
// is preserved and nothing is dropped or repeated.
module pixel_skid_reg #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_in_valid,
  input  logic [DATA_WIDTH-1:0] i_in_data,
  input  logic                  i_stall,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_skid_valid
);

  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_skid_valid;
  logic [DATA_WIDTH-1:0] r_skid_data;
  logic                  w_out_free;

  // Output register may take a new pixel when empty or when its pixel is consumed.
  assign w_out_free = ~r_out_valid | ~i_stall;

  // Output/skid update: skid drains first, then fresh memory data.
  // NOTE: all state here uses non-blocking assignments so every flop samples
  // the pre-edge values, regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: data registers are reset too, because the pixel output must
      // read zero out of reset rather than an arbitrary stale value.
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
    end else if (w_out_free) begin
      if (r_skid_valid) begin
        r_out_data   <= r_skid_data;
        r_out_valid  <= 1'b1;
        r_skid_valid <= i_in_valid;
        if (i_in_valid) r_skid_data <= i_in_data;
      end else if (i_in_valid) begin
        r_out_data  <= i_in_data;
        r_out_valid <= 1'b1;
      end else begin
        // Pixel value is kept; only the valid flag drops.
        r_out_valid <= 1'b0;
      end
    end else if (i_in_valid) begin
      // Output is occupied and stalled: park the returning word.
      r_skid_data  <= i_in_data;
      r_skid_valid <= 1'b1;
    end
  end

  assign o_valid      = r_out_valid;
  assign o_data       = r_out_data;
  assign o_skid_valid = r_skid_valid;

endmodule

// File: rtl/pixel_stream_tx.sv
// Frame transmitter: reads a frame from memory in raster order and streams it
// to a line-buffer chain with a valid/stall handshake, tagging row and frame
// ends. Memory latency is one cycle; the skid entry absorbs the one read that
// can be in flight when the downstream stalls.
module pixel_stream_tx
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int IMG_WIDTH  = 28,
  parameter int IMG_HEIGHT = 28,
  parameter int ADDR_WIDTH = 10
) (
  input  logic            clk,
  input  logic            rst,
  pixel_stream_tx_if.master bus
);

  localparam int PIX_COUNT = IMG_WIDTH * IMG_HEIGHT;
  localparam int COL_W     = cnt_width(IMG_WIDTH);
  localparam int ROW_W     = cnt_width(IMG_HEIGHT);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(PIX_COUNT - 1);
  localparam logic [COL_W-1:0]      LAST_COL  = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0]      LAST_ROW  = ROW_W'(IMG_HEIGHT - 1);

  tx_state_t             r_state;
  tx_state_t             w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic                  r_rd_pending;
  logic [COL_W-1:0]      r_col;
  logic [ROW_W-1:0]      r_row;

  logic                  w_rd;
  logic                  w_valid;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  w_skid_valid;
  logic                  w_consume;
  logic                  w_last_col;
  logic                  w_last_row;
  logic                  w_start;

  assign w_start    = (r_state == ST_IDLE) && bus.i_start;
  assign w_consume  = w_valid & ~bus.i_stall;
  assign w_last_col = (r_col == LAST_COL);
  assign w_last_row = (r_row == LAST_ROW);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state and read strobe.
  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave it unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_rd        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.i_start) w_state_nxt = ST_STREAM;
      end
      ST_STREAM: begin
        // Never issue a read that could return into a full skid entry.
        w_rd = ~bus.i_stall & ~w_skid_valid;
        if (w_rd && (r_rd_addr == LAST_ADDR)) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_consume && w_last_col && w_last_row) w_state_nxt = ST_FIN;
      end
      ST_FIN: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Read address, read-return tracking and position of the presented pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_addr    <= '0;
      r_rd_pending <= 1'b0;
      r_col        <= '0;
      r_row        <= '0;
    end else begin
      r_rd_pending <= w_rd;
      if (w_start) begin
        r_rd_addr <= '0;
        r_col     <= '0;
        r_row     <= '0;
      end else begin
        // Address parks on the last pixel once the frame has been read.
        if (w_rd && (r_rd_addr != LAST_ADDR)) r_rd_addr <= r_rd_addr + ADDR_WIDTH'(1);
        if (w_consume) begin
          if (w_last_col) begin
            r_col <= '0;
            r_row <= w_last_row ? '0 : r_row + ROW_W'(1);
          end else begin
            r_col <= r_col + COL_W'(1);
          end
        end
      end
    end
  end

  pixel_skid_reg #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk          (clk),
    .rst          (rst),
    .i_in_valid   (r_rd_pending),
    .i_in_data    (bus.i_mem_data),
    .i_stall      (bus.i_stall),
    .o_valid      (w_valid),
    .o_data       (w_data),
    .o_skid_valid (w_skid_valid)
  );

  assign bus.o_mem_rd    = w_rd;
  assign bus.o_mem_addr  = r_rd_addr;
  assign bus.o_out       = w_data;
  assign bus.o_e         = w_valid;
  assign bus.o_row_end   = w_valid & w_last_col;
  assign bus.o_frame_end = w_valid & w_last_col & w_last_row;
  assign bus.o_busy      = (r_state != ST_IDLE);
  assign bus.o_done      = (r_state == ST_FIN);

endmodule

// File: tb/tb_pixel_stream_tx.sv
// Bench for pixel_stream_tx on a 4x3 frame; memory word at address a is 0x100+a.
module tb_pixel_stream_tx;

  localparam int DW   = 16;
  localparam int AW   = 10;
  localparam int W    = 4;
  localparam int H    = 3;
  localparam int NPIX = W * H;

  typedef struct {
    bit start;
    bit stall;
    bit mem_rd;
    int addr;
    bit e;
    int pix;
    bit row_end;
    bit frame_end;
    bit busy;
    bit done;
  } vec_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_err;

  pixel_stream_tx_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  pixel_stream_tx #(
    .DATA_WIDTH (DW),
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: one-cycle read latency, junk when no read was issued.
  logic [DW-1:0] r_mem_data;
  always @(posedge clk) r_mem_data <= bus.o_mem_rd ? (16'h100 + DW'(bus.o_mem_addr)) : 16'hDEAD;
  assign bus.i_mem_data = r_mem_data;

  // Monitor: records issued read addresses and consumed pixels.
  bit      mon_en;
  int      rd_q[$];
  int      pix_q[$];
  bit      re_q[$];
  bit      fe_q[$];
  int      inflight;
  int      max_inflight;

  initial begin
    mon_en = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en && !rst) begin
        if (bus.o_mem_rd) begin
          rd_q.push_back(int'(bus.o_mem_addr));
          inflight++;
        end
        if (bus.o_e && !bus.i_stall) begin
          pix_q.push_back(int'(bus.o_out));
          re_q.push_back(bus.o_row_end);
          fe_q.push_back(bus.o_frame_end);
          inflight--;
        end
        if (inflight > max_inflight) max_inflight = inflight;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: drive inputs just after the edge, leave settle time before sampling.
  task automatic cycle(input bit start, input bit stall);
    @(posedge clk);
    #1;
    bus.i_start = start;
    bus.i_stall = stall;
    #1;
  endtask

  function automatic vec_t mk(input bit st, input bit sl, input bit rd, input int addr,
                              input bit e, input int pix, input bit re, input bit fe,
                              input bit bz, input bit dn);
    vec_t v;
    v.start = st; v.stall = sl; v.mem_rd = rd; v.addr = addr; v.e = e; v.pix = pix;
    v.row_end = re; v.frame_end = fe; v.busy = bz; v.done = dn;
    return v;
  endfunction

  // Check the whole recorded frame: raster addresses, pixel order and tags.
  task automatic check_frame(input string tag);
    check({tag, "_n_reads"}, rd_q.size(), NPIX);
    check({tag, "_n_pix"}, pix_q.size(), NPIX);
    for (int i = 0; i < NPIX && i < rd_q.size(); i++)
      check($sformatf("%s_rd_addr[%0d]", tag, i), rd_q[i], i);
    for (int i = 0; i < NPIX && i < pix_q.size(); i++) begin
      check($sformatf("%s_pix[%0d]", tag, i), pix_q[i], 32'h100 + i);
      check($sformatf("%s_row_end[%0d]", tag, i), re_q[i], (i % W) == (W - 1));
      check($sformatf("%s_frame_end[%0d]", tag, i), fe_q[i], i == NPIX - 1);
    end
    check({tag, "_inflight_le3"}, max_inflight <= 3, 1'b1);
  endtask

  // Run one frame to DONE with a bounded cycle budget.
  task automatic run_frame(input int stall_pct, input int mid_start_at, input string tag);
    bit seen_done;
    seen_done = 1'b0;
    rd_q.delete(); pix_q.delete(); re_q.delete(); fe_q.delete();
    inflight = 0; max_inflight = 0;
    mon_en = 1'b1;
    cycle(1'b1, 1'b0);
    for (int i = 1; i < 400 && !seen_done; i++) begin
      cycle(i == mid_start_at, ($urandom_range(0, 99) < stall_pct));
      if (bus.o_done) seen_done = 1'b1;
    end
    mon_en = 1'b0;
    check({tag, "_done_seen"}, seen_done, 1'b1);
    check_frame(tag);
  endtask

  vec_t vecs[$];
  vec_t v;
  bit   found;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_err    = 0;
    rst         = 1'b0;
    bus.i_start = 1'b0;
    bus.i_stall = 1'b0;

    // Run 1: unstalled frame; START is also pulsed during DONE (must be ignored).
    for (int c = 0; c < 17; c++)
      vecs.push_back(mk(c == 0 || c == 15, 1'b0, c >= 1 && c <= 12, c - 1,
                        c >= 3 && c <= 14, 'h100 + c - 3,
                        (c >= 3 && c <= 14) && ((c - 3) % W == W - 1), c == 14,
                        c >= 1 && c <= 15, c == 15));
    // Run 2: stall for 3 cycles while 0x105 is presented.
    vecs.push_back(mk(1, 0, 0,  0, 0, 0,     0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1,  0, 0, 0,     0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1,  1, 0, 0,     0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1,  2, 1, 'h100, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1,  3, 1, 'h101, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1,  4, 1, 'h102, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1,  5, 1, 'h103, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1,  6, 1, 'h104, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 0,  0, 1, 'h105, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 0,  0, 1, 'h105, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 0,  0, 1, 'h105, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0,  0, 1, 'h105, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1,  7, 1, 'h106, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1,  8, 0, 0,     0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1,  9, 1, 'h107, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 10, 1, 'h108, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 11, 1, 'h109, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0,  0, 1, 'h10A, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0,  0, 1, 'h10B, 1, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0,  0, 0, 0,     0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0,  0, 0, 0,     0, 0, 0, 0));

    // Reset state.
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out", bus.o_out, 0);
    check("rst_e", bus.o_e, 0);
    check("rst_busy", bus.o_busy, 0);
    check("rst_done", bus.o_done, 0);
    check("rst_mem_rd", bus.o_mem_rd, 0);
    check("rst_mem_addr", bus.o_mem_addr, 0);
    rst = 1'b0;

    // Cycle-accurate vectors.
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      cycle(v.start, v.stall);
      check($sformatf("vec%0d_mem_rd", i), bus.o_mem_rd, v.mem_rd);
      if (v.mem_rd) check($sformatf("vec%0d_mem_addr", i), bus.o_mem_addr, v.addr);
      check($sformatf("vec%0d_e", i), bus.o_e, v.e);
      if (v.e) check($sformatf("vec%0d_out", i), bus.o_out, v.pix);
      check($sformatf("vec%0d_row_end", i), bus.o_row_end, v.row_end);
      check($sformatf("vec%0d_frame_end", i), bus.o_frame_end, v.frame_end);
      check($sformatf("vec%0d_busy", i), bus.o_busy, v.busy);
      check($sformatf("vec%0d_done", i), bus.o_done, v.done);
    end

    // Random 50% stall.
    run_frame(50, -1, "rand_stall");
    // START pulsed mid-frame must not restart addressing.
    run_frame(0, 5, "mid_start");

    // Reset mid-frame right after 0x106 is presented, with a read in flight.
    found = 1'b0;
    cycle(1'b1, 1'b0);
    for (int i = 0; i < 40 && !found; i++) begin
      cycle(1'b0, 1'b0);
      if (bus.o_e && bus.o_out == 16'h106) found = 1'b1;
    end
    check("rst_mid_reach_106", found, 1'b1);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst_mid_out", bus.o_out, 0);
    check("rst_mid_e", bus.o_e, 0);
    check("rst_mid_row_end", bus.o_row_end, 0);
    check("rst_mid_frame_end", bus.o_frame_end, 0);
    check("rst_mid_busy", bus.o_busy, 0);
    check("rst_mid_done", bus.o_done, 0);
    check("rst_mid_mem_rd", bus.o_mem_rd, 0);
    check("rst_mid_mem_addr", bus.o_mem_addr, 0);
    #2 rst = 1'b0;
    // Word returning from the aborted read must not surface.
    cycle(1'b0, 1'b0);
    check("rst_mid_discard_e", bus.o_e, 0);
    check("rst_mid_idle", bus.o_busy, 0);
    run_frame(0, -1, "rst_restart");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
